// File: rtl/modulo_arbitro_buffer_rolhas_pkg.sv
// Shared constants and state encoding for the stopper buffer arbiter.
// Build option: ROLHAS_PRIORIDADE_RODIZIO_EN (round-robin VEDA/OPERA, see top).
package pkg_rolhas;

  localparam int LARGURA       = 7;
  localparam int MAX_ROLHAS    = 99;
  localparam int MIN_ROLHAS    = 5;
  localparam int LOTE          = 20;
  localparam int CARGA_INICIAL = 21;

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    TRANSFERE = 2'd1,
    VEDA      = 2'd2,
    OPERA     = 2'd3
  } estado_t;

endpackage

// File: rtl/modulo_arbitro_buffer_rolhas_if.sv
// Requester handshake bundle: level req held until a one-cycle ack pulse.
// The requester drops req during the ack cycle; a req still high back in OCIOSO is a new request.
interface modulo_arbitro_buffer_rolhas_if;

  logic req_vedacao;
  logic req_operador;
  logic ack_vedacao;
  logic ack_operador;
  logic erro_vazio;
  logic cheio;

  modport master (
    output req_vedacao, req_operador,
    input  ack_vedacao, ack_operador, erro_vazio, cheio
  );

  modport slave (
    input  req_vedacao, req_operador,
    output ack_vedacao, ack_operador, erro_vazio, cheio
  );

endinterface

// File: rtl/modulo_arbitro_buffer_rolhas_calc.sv
// Combinational transfer size: min(LOTE, feeder, room left in the main register).
module modulo_calc_transferencia
  import pkg_rolhas::*;
(
  input  logic [LARGURA-1:0] principal,
  input  logic [LARGURA-1:0] secundario,
  output logic [LARGURA-1:0] q
);

  localparam logic [LARGURA-1:0] MAX_V  = LARGURA'(MAX_ROLHAS);
  localparam logic [LARGURA-1:0] LOTE_V = LARGURA'(LOTE);

  logic [LARGURA-1:0] espaco;
  logic [LARGURA-1:0] menor_lote;

  always_comb begin
    espaco     = (principal >= MAX_V) ? '0 : MAX_V - principal;
    menor_lote = (secundario < LOTE_V) ? secundario : LOTE_V;
    q          = (espaco < menor_lote) ? espaco : menor_lote;
  end

endmodule

// File: rtl/modulo_arbitro_buffer_rolhas.sv
// Sole owner of the main/feeder stopper registers; grants one update per two cycles.
// Build option: ROLHAS_PRIORIDADE_RODIZIO_EN alternates VEDA/OPERA priority (TRANSFERE stays highest).
module modulo_arbitro_buffer_rolhas
  import pkg_rolhas::*;
(
  input  logic                clk,
  input  logic                Nclr,
  input  logic                enable,
  input  logic                carga_sec,
  input  logic [LARGURA-1:0]  valor_sec,
  modulo_arbitro_buffer_rolhas_if.slave bus,
  output logic [LARGURA-1:0]  rolhas_principal,
  output logic [LARGURA-1:0]  rolhas_secundario,
  output logic                ro,
  output logic                min_r,
  output logic [1:0]          estado
);

  localparam logic [LARGURA-1:0] MAX_V   = LARGURA'(MAX_ROLHAS);
  localparam logic [LARGURA-1:0] MIN_V   = LARGURA'(MIN_ROLHAS);
  localparam logic [LARGURA-1:0] CARGA_V = LARGURA'(CARGA_INICIAL);
  localparam logic [LARGURA-1:0] UM      = LARGURA'(1);

  estado_t            estado_q, estado_d;
  logic [LARGURA-1:0] principal_q, principal_d;
  logic [LARGURA-1:0] secundario_q, secundario_d;
  logic [LARGURA-1:0] q;
  logic               erro_q, erro_d;
  logic               cheio_q, cheio_d;
  logic               veda_vence;

  modulo_calc_transferencia u_calc (
    .principal  (principal_q),
    .secundario (secundario_q),
    .q          (q)
  );

  assign ro    = (principal_q == '0);
  assign min_r = (principal_q < MIN_V);

`ifdef ROLHAS_PRIORIDADE_RODIZIO_EN
  // Set when VEDA was the last grant, so OPERA wins the next tie.
  logic ultimo_veda_q;

  always_ff @(posedge clk or negedge Nclr) begin
    if (!Nclr) begin
      ultimo_veda_q <= 1'b0;
    end else if (estado_q == OCIOSO && estado_d == VEDA) begin
      ultimo_veda_q <= 1'b1;
    end else if (estado_q == OCIOSO && estado_d == OPERA) begin
      ultimo_veda_q <= 1'b0;
    end
  end

  assign veda_vence = bus.req_vedacao && (!bus.req_operador || !ultimo_veda_q);
`else
  assign veda_vence = bus.req_vedacao;
`endif

  always_ff @(posedge clk or negedge Nclr) begin
    if (!Nclr) begin
      estado_q     <= OCIOSO;
      principal_q  <= '0;
      secundario_q <= '0;
      erro_q       <= 1'b0;
      cheio_q      <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      principal_q  <= principal_d;
      secundario_q <= secundario_d;
      erro_q       <= erro_d;
      cheio_q      <= cheio_d;
    end
  end

  // Grant and register update share the edge that leaves OCIOSO; every granted state lasts one cycle.
  always_comb begin
    estado_d     = estado_q;
    principal_d  = principal_q;
    secundario_d = secundario_q;
    erro_d       = 1'b0;
    cheio_d      = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (enable) begin
          if (min_r && secundario_q != '0) begin
            estado_d     = TRANSFERE;
            principal_d  = principal_q + q;
            secundario_d = secundario_q - q;
          end else if (veda_vence) begin
            estado_d = VEDA;
            if (principal_q != '0) principal_d = principal_q - UM;
            else                   erro_d      = 1'b1;
          end else if (bus.req_operador) begin
            estado_d = OPERA;
            if (principal_q < MAX_V) principal_d = principal_q + UM;
            else                     cheio_d     = 1'b1;
          end
        end else if (carga_sec) begin
          secundario_d = (valor_sec > MAX_V) ? MAX_V : valor_sec;
          principal_d  = CARGA_V;
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  assign bus.ack_vedacao  = (estado_q == VEDA);
  assign bus.ack_operador = (estado_q == OPERA);
  assign bus.erro_vazio   = erro_q;
  assign bus.cheio        = cheio_q;

  assign rolhas_principal  = principal_q;
  assign rolhas_secundario = secundario_q;
  assign estado            = estado_q;

endmodule

// File: tb/tb_modulo_arbitro_buffer_rolhas.sv
// Bench for the stopper buffer arbiter: directed scenarios plus random traffic vs. a behavioural model.
// Also valid when built with ROLHAS_PRIORIDADE_RODIZIO_EN.
module tb_modulo_arbitro_buffer_rolhas;

  logic                         clk;
  logic                         Nclr;
  logic                         enable;
  logic                         carga_sec;
  logic [pkg_rolhas::LARGURA-1:0] valor_sec;
  logic [pkg_rolhas::LARGURA-1:0] rolhas_principal;
  logic [pkg_rolhas::LARGURA-1:0] rolhas_secundario;
  logic                         ro;
  logic                         min_r;
  logic [1:0]                   estado;

  modulo_arbitro_buffer_rolhas_if bus ();

  modulo_arbitro_buffer_rolhas dut (
    .clk               (clk),
    .Nclr              (Nclr),
    .enable            (enable),
    .carga_sec         (carga_sec),
    .valor_sec         (valor_sec),
    .bus               (bus.slave),
    .rolhas_principal  (rolhas_principal),
    .rolhas_secundario (rolhas_secundario),
    .ro                (ro),
    .min_r             (min_r),
    .estado            (estado)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Model state: stopper counts, phase (0 idle, 1 transfer, 2 capping, 3 operator), pulse flags.
  int m_p, m_s, m_st;
  bit m_err, m_cheio, m_last_veda;

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_p = 0; m_s = 0; m_st = 0; m_err = 0; m_cheio = 0; m_last_veda = 0;
  endtask

  task automatic model_edge();
    int  q;
    bit  v_win;
    m_err   = 0;
    m_cheio = 0;
    if (m_st != 0) begin
      m_st = 0;
      return;
    end
    if (enable) begin
`ifdef ROLHAS_PRIORIDADE_RODIZIO_EN
      v_win = bus.req_vedacao && (!bus.req_operador || !m_last_veda);
`else
      v_win = bus.req_vedacao;
`endif
      if (m_p < 5 && m_s > 0) begin
        q = min_int(20, min_int(m_s, 99 - m_p));
        m_p += q;
        m_s -= q;
        m_st = 1;
      end else if (v_win) begin
        m_st = 2;
        m_last_veda = 1;
        if (m_p > 0) m_p--; else m_err = 1;
      end else if (bus.req_operador) begin
        m_st = 3;
        m_last_veda = 0;
        if (m_p < 99) m_p++; else m_cheio = 1;
      end
    end else if (carga_sec) begin
      m_s = (int'(valor_sec) > 99) ? 99 : int'(valor_sec);
      m_p = 21;
    end
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".estado"},  estado,             m_st);
    check_val({tag, ".princ"},   rolhas_principal,   m_p);
    check_val({tag, ".sec"},     rolhas_secundario,  m_s);
    check_val({tag, ".ack_v"},   bus.ack_vedacao,    (m_st == 2));
    check_val({tag, ".ack_o"},   bus.ack_operador,   (m_st == 3));
    check_val({tag, ".erro"},    bus.erro_vazio,     m_err);
    check_val({tag, ".cheio"},   bus.cheio,          m_cheio);
    check_val({tag, ".ro"},      ro,                 (m_p == 0));
    check_val({tag, ".min_r"},   min_r,              (m_p < 5));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    Nclr = 1'b0;
    #2;
    model_reset();
    check_all(tag);
    @(negedge clk);
    Nclr = 1'b1;
  endtask

  task automatic carga(input int valor);
    enable    = 1'b0;
    carga_sec = 1'b1;
    valor_sec = 7'(valor);
    step("carga");
    carga_sec = 1'b0;
  endtask

  task automatic veda_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus.req_vedacao = 1'b1;
      step("veda");
      bus.req_vedacao = 1'b0;
      step("veda_ret");
    end
  endtask

  task automatic opera_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus.req_operador = 1'b1;
      step("opera");
      bus.req_operador = 1'b0;
      step("opera_ret");
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bias_o;
    Nclr = 1'b0; enable = 1'b0; carga_sec = 1'b0; valor_sec = '0;
    bus.req_vedacao = 1'b0; bus.req_operador = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    Nclr = 1'b1;

    // T1: load, with and without clamping of the feeder value
    carga(40);
    check_val("t1_princ", rolhas_principal, 21);
    check_val("t1_sec", rolhas_secundario, 40);
    carga(120);
    check_val("t1_sec_clamp", rolhas_secundario, 99);

    // T2: capping grant then return to idle
    enable = 1'b1;
    bus.req_vedacao = 1'b1;
    step("t2_grant");
    check_val("t2_estado", estado, 2);
    check_val("t2_ack", bus.ack_vedacao, 1);
    check_val("t2_princ", rolhas_principal, 20);
    bus.req_vedacao = 1'b0;
    step("t2_ret");
    check_val("t2_idle", estado, 0);

    // T3: automatic refill, limited by LOTE then by the feeder
    carga(40);
    enable = 1'b1;
    veda_n(17);
    check_val("t3_p4", rolhas_principal, 4);
    step("t3_xfer");
    check_val("t3_estado", estado, 1);
    check_val("t3_princ", rolhas_principal, 24);
    check_val("t3_sec", rolhas_secundario, 20);
    step("t3_ret");
    carga(7);
    enable = 1'b1;
    veda_n(17);
    step("t3_xfer2");
    check_val("t3_princ2", rolhas_principal, 11);
    check_val("t3_sec2", rolhas_secundario, 0);
    step("t3_ret2");

    // T4: both requesters against a pending refill
    carga(30);
    enable = 1'b1;
    veda_n(17);
    bus.req_vedacao = 1'b1; bus.req_operador = 1'b1;
    step("t4_xfer");
    check_val("t4_xfer_estado", estado, 1);
    step("t4_ret1");
    step("t4_g2");
    if (m_st == 2) bus.req_vedacao = 1'b0;
    if (m_st == 3) bus.req_operador = 1'b0;
    step("t4_ret2");
    step("t4_g3");
    bus.req_vedacao = 1'b0; bus.req_operador = 1'b0;
    step("t4_ret3");

    // T5: empty and full boundaries
    carga(0);
    enable = 1'b1;
    veda_n(21);
    bus.req_vedacao = 1'b1;
    step("t5_vazio");
    check_val("t5_erro", bus.erro_vazio, 1);
    check_val("t5_ack", bus.ack_vedacao, 1);
    check_val("t5_ro", ro, 1);
    bus.req_vedacao = 1'b0;
    step("t5_ret");
    opera_n(99);
    check_val("t5_p99", rolhas_principal, 99);
    bus.req_operador = 1'b1;
    step("t5_cheio");
    check_val("t5_cheio", bus.cheio, 1);
    check_val("t5_p_hold", rolhas_principal, 99);
    bus.req_operador = 1'b0;
    step("t5_ret2");

    // enable=0: requests ignored, not queued
    enable = 1'b0;
    bus.req_vedacao = 1'b1;
    for (int i = 0; i < 3; i++) step("disabled");
    check_val("dis_idle", estado, 0);
    bus.req_vedacao = 1'b0;

    // T6: asynchronous reset during a capping cycle
    carga(0);
    enable = 1'b1;
    bus.req_vedacao = 1'b1;
    step("t6_veda");
    do_reset("t6_rst");
    check_val("t6_estado", estado, 0);
    check_val("t6_princ", rolhas_principal, 0);
    check_val("t6_ack", bus.ack_vedacao, 0);
    bus.req_vedacao = 1'b0;

    // Both requests held continuously: fixed or alternating priority
    carga(0);
    enable = 1'b1;
    bus.req_vedacao = 1'b1; bus.req_operador = 1'b1;
    for (int i = 0; i < 8; i++) step("both_held");
    bus.req_vedacao = 1'b0; bus.req_operador = 1'b0;
    step("both_ret");

    // Random traffic
    bias_o = 2;
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) bias_o = $urandom_range(1, 6);
      enable    = ($urandom_range(0, 9) != 0);
      carga_sec = !enable && ($urandom_range(0, 1) == 1);
      valor_sec = 7'($urandom_range(0, 127));
      if (m_st == 2)                bus.req_vedacao = 1'b0;
      else if (!bus.req_vedacao)    bus.req_vedacao = ($urandom_range(0, bias_o) == 0);
      if (m_st == 3)                bus.req_operador = 1'b0;
      else if (!bus.req_operador)   bus.req_operador = ($urandom_range(0, 6 - bias_o) == 0);
      if ($urandom_range(0, 399) == 0) do_reset("rnd_rst");
      else                             step("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
